dice_roll_ctrl: RTL
===================

Name: dice_roll_ctrl

Overview:
- Sequences one die roll for the dice game.
- Consumes single-cycle button pulses from the debounced button handlers (ROLL and CANCEL).
- Samples a free-running 1..DIE_MAX entropy counter at the press, then animates the die face through ROLL_STEPS timed steps.
- Presents the settled value with a one-cycle DONE pulse. Sits between the button handlers and the display/scoring logic.

Parameters:
- TICK_MAX, 4999999: step period minus one, in CLK cycles (T).
- ROLL_STEPS, 20: number of face advances per roll (N); must be ≥1.
- DIE_MAX, 6: highest face value; faces run 1..DIE_MAX.
- CNT_W, 8: width of the completed-roll counter.
- SLOW_STEPS, 3: number of decelerating final steps; used only with DICE_SLOWDOWN_EN.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ROLL_PULSE  in  1  one-cycle request to start a roll.
- CANCEL_PULSE  in  1  one-cycle request to abort a roll in progress.
- DIE_VALUE  out  3  current or settled face, 1..DIE_MAX.
- BUSY  out  1  high while rolling (SPIN state).
- DONE  out  1  one-cycle pulse when a roll settles.
- ROLL_COUNT  out  CNT_W  number of completed rolls, modulo 2^CNT_W.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). All outputs are registered.
- Reset values:
  - DIE_VALUE=1, BUSY=0, DONE=0, ROLL_COUNT=0.
  - State=IDLE; entropy counter=1; tick counter=0; step counter=0.
- Entropy counter:
  - Advances 1→2→…→DIE_MAX→1 every cycle, in every state.
  - Held only by RESET.
- States: IDLE, SPIN, DONE.
- IDLE:
  - On ROLL_PULSE, load DIE_VALUE with the current-cycle entropy value, clear the tick and step counters, go to SPIN.
  - BUSY=1 from the next cycle.
  - CANCEL_PULSE is ignored in IDLE.
- SPIN:
  - Tick counter counts 0..T; at T it wraps to 0 and a step occurs.
  - On each step, DIE_VALUE advances by 1, wrapping DIE_MAX→1, and the step counter increments.
  - Step k lands on the edge k·(T+1) cycles after the ROLL_PULSE edge.
  - The edge performing step N also sets DONE=1, BUSY=0, ROLL_COUNT+1 (wraps to 0), and moves to the DONE state.
- DONE: lasts exactly one cycle; DONE=0 on exit; go to IDLE.
  - A ROLL_PULSE in this cycle is accepted, exactly as in IDLE.
- Final value: ((S−1+N) mod DIE_MAX)+1, where S is the sampled entropy value.
- ROLL_PULSE during SPIN is ignored; no queueing.
- CANCEL_PULSE during SPIN:
  - Next state IDLE, BUSY=0.
  - DIE_VALUE keeps its current face; no DONE; ROLL_COUNT unchanged.
  - Cancel wins over a simultaneous step, including the final step.
- ROLL_PULSE and CANCEL_PULSE together: ROLL wins in IDLE/DONE; CANCEL wins in SPIN.
- RESET mid-roll: all registers return to reset values on that edge; no DONE.

Optional Feature:
- Macro: DICE_SLOWDOWN_EN.
- Defined:
  - The last SLOW_STEPS steps use period (T+1)·2^j, for j=1..SLOW_STEPS; the first N−SLOW_STEPS steps use T+1.
  - If N≤SLOW_STEPS, every step is a slow step, numbered from the end.
  - The tick counter is sized to hold (T+1)·2^SLOW_STEPS−1.
- Undefined: every step uses period T+1; SLOW_STEPS has no effect.
- Final value is identical in both builds.

Decomposition:
- Shared package dice_pkg:
  - State enum typedef (IDLE, SPIN, DONE).
  - DIE_W=3 and default DIE_MAX=6 constants.
  - Face-increment-with-wrap function, shared with the display and scoring logic.
- One sub-module, roll_tick_gen: tick counter with clear, period input, and one-cycle TICK output; it absorbs the slowdown period logic.
- The FSM, entropy counter and step counter stay in dice_roll_ctrl.

Test Plan:
- Reset: assert RESET 2 cycles → DIE_VALUE=1, BUSY=0, DONE=0, ROLL_COUNT=0.
- Basic roll (T=3, N=4, slowdown off), ROLL_PULSE while entropy=2:
  - BUSY=1 next cycle.
  - DIE_VALUE 3,4,5,6 at edges 4,8,12,16.
  - DONE high for the single cycle after edge 16; ROLL_COUNT=1.
- Wrap: entropy=3, N=4 → final DIE_VALUE=1.
- Interference during a roll:
  - ROLL_PULSE at cycle 6 is ignored: same step timing, ROLL_COUNT=1.
  - CANCEL at cycle 10 → BUSY=0 at cycle 11, DIE_VALUE frozen at 4, no DONE, ROLL_COUNT unchanged.
- Reset mid-roll: RESET at cycle 9 → reset values at next edge, no DONE; a following ROLL_PULSE starts a clean roll.
- DICE_SLOWDOWN_EN (T=3, N=4, SLOW_STEPS=3):
  - Steps at edges 4, 12, 28, 60.
  - DONE high for the single cycle after edge 60.
  - Final value matches the non-slowdown build.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared dice definitions: FSM state encoding, face width and the face
// increment used by the roll controller, display and scoring logic.
package dice_pkg;
  localparam int DIE_W        = 3;
  localparam int DIE_MAX_DFLT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPIN,
    ST_DONE
  } state_e;

  function automatic logic [DIE_W-1:0] face_inc(input logic [DIE_W-1:0] f,
                                                input logic [DIE_W-1:0] fmax);
    return (f >= fmax) ? DIE_W'(1) : f + DIE_W'(1);
  endfunction
endpackage

// File: rtl/roll_tick_gen.sv
// Step timer for the die animation: counts 0..period and pulses tick_o on
// wrap. With DICE_SLOWDOWN_EN the final SLOW_STEPS steps double in length.
module roll_tick_gen
  import dice_pkg::*;
#(
  parameter int TICK_MAX   = 4999999,
  parameter int ROLL_STEPS = 20,
  parameter int SLOW_STEPS = 3,
  parameter int SW         = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [SW-1:0] step_i,
  output logic          tick_o
);
`ifdef DICE_SLOWDOWN_EN
  localparam int MAXP = ((TICK_MAX + 1) << SLOW_STEPS) - 1;
`else
  localparam int MAXP = TICK_MAX;
`endif
  localparam int TW = (MAXP > 0) ? $clog2(MAXP + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d, period;

`ifdef DICE_SLOWDOWN_EN
  int rem;
  // rem counts the upcoming step too, so the final step gets the longest period
  always_comb begin
    rem    = ROLL_STEPS - int'(step_i);
    period = TW'(TICK_MAX);
    if (rem <= SLOW_STEPS)
      period = TW'(((TICK_MAX + 1) << (SLOW_STEPS - rem + 1)) - 1);
  end
`else
  logic unused_step;
  assign unused_step = ^step_i;
  assign period      = TW'(TICK_MAX);
`endif

  assign tick_o = en_i && (cnt_q == period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dice_roll_ctrl.sv
// Die roll sequencer: samples a free-running entropy face on ROLL, animates
// ROLL_STEPS timed steps, then pulses DONE. Optional: DICE_SLOWDOWN_EN.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TICK_MAX   = 4999999,
  parameter int ROLL_STEPS = 20,
  parameter int DIE_MAX    = DIE_MAX_DFLT,
  parameter int CNT_W      = 8,
  parameter int SLOW_STEPS = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ROLL_PULSE,
  input  logic             CANCEL_PULSE,
  output logic [DIE_W-1:0] DIE_VALUE,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ROLL_COUNT
);
  localparam int               SW   = $clog2(ROLL_STEPS + 1);
  localparam logic [DIE_W-1:0] FMAX = DIE_W'(DIE_MAX);
  localparam logic [SW-1:0]    LAST = SW'(ROLL_STEPS - 1);

  state_e           state_q, state_d;
  logic [DIE_W-1:0] ent_q, ent_d, die_q, die_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             tick, tick_clr;

  roll_tick_gen #(
    .TICK_MAX  (TICK_MAX),
    .ROLL_STEPS(ROLL_STEPS),
    .SLOW_STEPS(SLOW_STEPS),
    .SW        (SW)
  ) u_tick (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (tick_clr),
    .en_i  (state_q == ST_SPIN),
    .step_i(step_q),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    ent_d    = face_inc(ent_q, FMAX);
    die_d    = die_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tick_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (ROLL_PULSE) begin
          state_d  = ST_SPIN;
          die_d    = ent_q;
          step_d   = '0;
          busy_d   = 1'b1;
          tick_clr = 1'b1;
        end
      end
      ST_SPIN: begin
        // cancel beats a coinciding step, including the final one
        if (CANCEL_PULSE) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (tick) begin
          die_d  = face_inc(die_q, FMAX);
          step_d = step_q + SW'(1);
          if (step_q == LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ent_q   <= DIE_W'(1);
      die_q   <= DIE_W'(1);
      step_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      die_q   <= die_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DIE_VALUE  = die_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ROLL_COUNT = cnt_q;
endmodule
